// File: rtl/atomik_reset_sequencer.sv
// Node bring-up manager: power-on delay, filtered PLL lock, then staggered release of N_DOM
// reset domains with per-domain gating; re-sequences through HOLD on lock loss or soft reset.
module atomik_reset_sequencer #(
  parameter int unsigned POR_CYCLES  = 65535,
  parameter int unsigned N_DOM       = 3,
  parameter int unsigned GAP_CYCLES  = 256,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic [N_DOM-1:0] dom_enable,
  input  logic [N_DOM-1:0] force_en,
  input  logic             soft_rst_req,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             sys_ready,
  output logic [2:0]       seq_state,
  output logic [7:0]       lock_loss_cnt
);

  typedef enum logic [2:0] {
    StPor      = 3'd0,
    StWaitLock = 3'd1,
    StRelease  = 3'd2,
    StRun      = 3'd3,
    StHold     = 3'd4
  } state_e;

  localparam int unsigned PorW  = $clog2(POR_CYCLES + 1);
  localparam int unsigned FiltW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PorW-1:0]  PorMax  = PorW'(POR_CYCLES);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(LOCK_FILTER);
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [N_DOM-1:0] DomOne  = N_DOM'(1);

  state_e                 state_q, state_d;
  logic [PorW-1:0]        por_q, por_d;
  logic [FiltW-1:0]       filt_q, filt_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [N_DOM-1:0]       rel_q, rel_d;
  logic [7:0]             llc_q, llc_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    por_d   = por_q;
    filt_d  = filt_q;
    gap_d   = gap_q;
    rel_d   = rel_q;
    llc_d   = llc_q;
    unique case (state_q)
      StPor: begin
        if (por_q == PorMax) begin
          state_d = StWaitLock;
        end else begin
          por_d = por_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (filt_q == FiltMax) begin
          state_d = StRelease;
          rel_d   = DomOne;
          gap_d   = '0;
          filt_d  = '0;
        end else if (lock_s) begin
          filt_d = filt_q + 1'b1;
        end else begin
          filt_d = '0;
        end
      end
      StRelease, StRun: begin
        if (!lock_s || soft_rst_req) begin
          state_d = StHold;
          rel_d   = '0;
          gap_d   = '0;
          // Lock loss counts even when it coincides with a soft reset request.
          if (!lock_s && (llc_q != 8'hff)) begin
            llc_d = llc_q + 1'b1;
          end
        end else if (state_q == StRelease) begin
          if (gap_q == GapLast) begin
            gap_d = '0;
            if (rel_q[N_DOM-1]) begin
              state_d = StRun;
            end else begin
              rel_d = (rel_q << 1) | DomOne;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (gap_q == GapLast) begin
          state_d = StWaitLock;
          gap_d   = '0;
          filt_d  = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StPor;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPor;
      por_q     <= '0;
      filt_q    <= '0;
      gap_q     <= '0;
      rel_q     <= '0;
      llc_q     <= '0;
      sync_q    <= '0;
      dom_rst_n <= '0;
    end else begin
      state_q   <= state_d;
      por_q     <= por_d;
      filt_q    <= filt_d;
      gap_q     <= gap_d;
      rel_q     <= rel_d;
      llc_q     <= llc_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      // Built from the next mask so a fault drops every domain on the same edge as HOLD.
      dom_rst_n <= rel_d & (dom_enable | force_en);
    end
  end

  assign sys_ready     = (state_q == StRun);
  assign seq_state     = state_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_atomik_reset_sequencer.sv
// Bench for atomik_reset_sequencer: timeline model checked every cycle plus directed literals.
module tb_atomik_reset_sequencer;

  localparam int unsigned POR  = 8;
  localparam int unsigned ND   = 3;
  localparam int unsigned GAP  = 4;
  localparam int unsigned FILT = 4;
  localparam int unsigned SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic [ND-1:0] dom_enable;
  logic [ND-1:0] force_en;
  logic          soft_rst_req;
  logic [ND-1:0] dom_rst_n;
  logic          sys_ready;
  logic [2:0]    seq_state;
  logic [7:0]    lock_loss_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: phase (0..4), edge index it was entered at, lock run length, lock-loss count.
  int            cyc;
  int            m_phase;
  int            m_start;
  int            m_run;
  int            m_llc;
  bit            m_q[$];
  logic [ND-1:0] m_dom;

  always #5 clk = ~clk;

  atomik_reset_sequencer #(
    .POR_CYCLES (POR),
    .N_DOM      (ND),
    .GAP_CYCLES (GAP),
    .LOCK_FILTER(FILT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .dom_enable   (dom_enable),
    .force_en     (force_en),
    .soft_rst_req (soft_rst_req),
    .dom_rst_n    (dom_rst_n),
    .sys_ready    (sys_ready),
    .seq_state    (seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ND-1:0] rel_mask(input int k);
    logic [ND-1:0] m;
    m = '0;
    for (int i = 0; i < k && i < ND; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Domains released so far: one at release entry, one more per elapsed gap.
  function automatic int rel_count(input int ph, input int el);
    if (ph == 3) return ND;
    if (ph == 2) return (el / GAP + 1 > ND) ? ND : el / GAP + 1;
    return 0;
  endfunction

  task automatic model_reset();
    cyc     = 0;
    m_phase = 0;
    m_start = 0;
    m_run   = 0;
    m_llc   = 0;
    m_dom   = '0;
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit ls;
    int el;
    cyc++;
    ls = m_q.pop_front();
    m_q.push_back(pll_lock);
    el = cyc - m_start;
    case (m_phase)
      0: if (el == POR + 1) begin m_phase = 1; m_start = cyc; m_run = 0; end
      1: begin
        if (m_run == FILT) begin m_phase = 2; m_start = cyc; end
        else m_run = ls ? m_run + 1 : 0;
      end
      2, 3: begin
        if (!ls || soft_rst_req) begin
          m_phase = 4;
          m_start = cyc;
          if (!ls && m_llc < 255) m_llc++;
        end else if (m_phase == 2 && el == ND * GAP) begin
          m_phase = 3;
          m_start = cyc;
        end
      end
      default: if (el == GAP) begin m_phase = 1; m_start = cyc; m_run = 0; end
    endcase
    m_dom = rel_mask(rel_count(m_phase, cyc - m_start)) & (dom_enable | force_en);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model dom_rst_n", 32'(dom_rst_n), 32'(m_dom));
      chk("model sys_ready", 32'(sys_ready), 32'(m_phase == 3));
      chk("model seq_state", 32'(seq_state), 32'(m_phase));
      chk("model lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_llc));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the falling edge after rising edge n; inputs set here are sampled at edge n+1.
  task automatic goto_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget);
    int i;
    i = 0;
    while (!sys_ready && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (!sys_ready) begin
      failures++;
      $display("FAIL wait_ready: sys_ready still %0b after %0d cycles, required 1", sys_ready, budget);
    end
  endtask

  task automatic check_bringup(input string tag);
    goto_edge(8);  chk({tag, " seq@8"}, 32'(seq_state), 0);
    goto_edge(9);  chk({tag, " seq@9"}, 32'(seq_state), 1);
    goto_edge(13); chk({tag, " dom@13"}, 32'(dom_rst_n), 32'b000);
    goto_edge(14); chk({tag, " dom@14"}, 32'(dom_rst_n), 32'b001);
                   chk({tag, " seq@14"}, 32'(seq_state), 2);
    goto_edge(17); chk({tag, " dom@17"}, 32'(dom_rst_n), 32'b001);
    goto_edge(18); chk({tag, " dom@18"}, 32'(dom_rst_n), 32'b011);
    goto_edge(22); chk({tag, " dom@22"}, 32'(dom_rst_n), 32'b111);
    goto_edge(25); chk({tag, " ready@25"}, 32'(sys_ready), 0);
    goto_edge(26); chk({tag, " ready@26"}, 32'(sys_ready), 1);
                   chk({tag, " seq@26"}, 32'(seq_state), 3);
  endtask

  initial begin
    int e;
    rst_n        = 1'b0;
    pll_lock     = 1'b1;
    dom_enable   = 3'b111;
    force_en     = 3'b000;
    soft_rst_req = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset dom", 32'(dom_rst_n), 0);
    chk("reset seq", 32'(seq_state), 0);

    // 1: clean bring-up
    do_reset();
    check_bringup("s1");

    // 2: late lock, then a one-cycle drop during filtering
    pll_lock = 1'b0;
    do_reset();
    goto_edge(20); pll_lock = 1'b1;
    goto_edge(26); chk("s2 dom@26", 32'(dom_rst_n), 0);
    goto_edge(27); chk("s2 dom@27", 32'(dom_rst_n), 32'b001);
    pll_lock = 1'b0;
    do_reset();
    goto_edge(20); pll_lock = 1'b1;
    goto_edge(23); pll_lock = 1'b0;
    goto_edge(24); pll_lock = 1'b1;
    goto_edge(30); chk("s2b dom@30", 32'(dom_rst_n), 0);
                   chk("s2b seq@30", 32'(seq_state), 1);
    goto_edge(31); chk("s2b dom@31", 32'(dom_rst_n), 32'b001);

    // 3: lock loss in RUN, repeated to saturation
    do_reset();
    goto_edge(26);
    e = cyc;
    pll_lock = 1'b0;
    goto_edge(e + 1); pll_lock = 1'b1;
    goto_edge(e + 2); chk("s3 seq@E+2", 32'(seq_state), 3);
    goto_edge(e + 3); chk("s3 dom@E+3", 32'(dom_rst_n), 0);
                      chk("s3 ready@E+3", 32'(sys_ready), 0);
                      chk("s3 seq@E+3", 32'(seq_state), 4);
                      chk("s3 llc", 32'(lock_loss_cnt), 1);
    goto_edge(e + 6); chk("s3 seq@E+6", 32'(seq_state), 4);
    goto_edge(e + 7); chk("s3 seq@E+7", 32'(seq_state), 1);
    wait_ready(100);
    for (int i = 1; i < 300; i++) begin
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      repeat (3) @(negedge clk);
      wait_ready(100);
    end
    chk("s3 llc sat", 32'(lock_loss_cnt), 255);

    // 4: soft reset ignored in POR/WAIT_LOCK, honoured in RUN
    do_reset();
    goto_edge(5);  soft_rst_req = 1'b1;
    goto_edge(6);  soft_rst_req = 1'b0;
    goto_edge(10); soft_rst_req = 1'b1;
    goto_edge(11); soft_rst_req = 1'b0;
    goto_edge(14); chk("s4 dom@14", 32'(dom_rst_n), 32'b001);
    goto_edge(26); chk("s4 ready@26", 32'(sys_ready), 1);
    soft_rst_req = 1'b1;
    goto_edge(27); soft_rst_req = 1'b0;
                   chk("s4 seq@27", 32'(seq_state), 4);
                   chk("s4 dom@27", 32'(dom_rst_n), 0);
                   chk("s4 llc", 32'(lock_loss_cnt), 0);
    goto_edge(31); chk("s4 seq@31", 32'(seq_state), 1);
    wait_ready(100);

    // 5: gated domain, late enable, then force-enable and enable drop
    dom_enable = 3'b011;
    do_reset();
    goto_edge(22); chk("s5 dom@22", 32'(dom_rst_n), 32'b011);
    goto_edge(26); chk("s5 ready@26", 32'(sys_ready), 1);
    goto_edge(40); chk("s5 dom@40", 32'(dom_rst_n), 32'b011);
    dom_enable = 3'b111;
    goto_edge(41); chk("s5 dom@41", 32'(dom_rst_n), 32'b111);
    dom_enable = 3'b011;
    do_reset();
    goto_edge(40); chk("s5f dom@40", 32'(dom_rst_n), 32'b011);
    force_en = 3'b100;
    goto_edge(41); chk("s5f dom@41", 32'(dom_rst_n), 32'b111);
    dom_enable = 3'b010;
    goto_edge(42); chk("s5f dom@42", 32'(dom_rst_n), 32'b110);
                   chk("s5f ready@42", 32'(sys_ready), 1);

    // 6: async reset mid-release, then identical bring-up
    dom_enable = 3'b111;
    force_en   = 3'b000;
    do_reset();
    goto_edge(16);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6 async dom", 32'(dom_rst_n), 0);
    chk("s6 async seq", 32'(seq_state), 0);
    chk("s6 async ready", 32'(sys_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_bringup("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atomik_reset_sequencer.md
Name: atomik_reset_sequencer

Overview:
- Parametrised reset/bring-up manager for ATOMiK nodes, successor to the fixed top-level POR/lock/reset-sync/core-gating logic.
- Runs a power-on delay, filters PLL lock, then releases N reset domains one at a time with a programmable gap.
- Gates each domain with its own enable (e.g. loader core_enable), and re-sequences on lock loss or soft-reset request.
- Sits in the top level between clocking and all functional blocks (loader, core, heartbeat).

Parameters:
- POR_CYCLES, 65535, power-on delay in clk cycles; must be > SYNC_STAGES.
- N_DOM, 3, number of reset domains; range 1..8.
- GAP_CYCLES, 256, cycles between successive domain releases, and the HOLD time after a fault; range >= 1.
- LOCK_FILTER, 16, consecutive synchronised-high lock cycles required before release starts; range >= 1.
- SYNC_STAGES, 2, flop stages on pll_lock; range >= 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- pll_lock, input, 1, PLL lock; asynchronous to clk.
- dom_enable, input, N_DOM, per-domain functional enable (level).
- force_en, input, N_DOM, per-domain debug force-enable (level).
- soft_rst_req, input, 1, single-cycle request to re-run the release sequence.
- dom_rst_n, output, N_DOM, per-domain active-low resets; registered.
- sys_ready, output, 1, high only in RUN.
- seq_state, output, 3, encoded state: POR=0, WAIT_LOCK=1, RELEASE=2, RUN=3, HOLD=4.
- lock_loss_cnt, output, 8, saturating count of lock-loss events.

Behaviour:
- Reset (rst_n low, async):
  - state=POR; all counters 0; released mask 0.
  - dom_rst_n=0, sys_ready=0, seq_state=0, lock_loss_cnt=0.
  - Sync chain cleared to 0.
- lock_s is pll_lock after SYNC_STAGES flops; all decisions use lock_s.
- POR:
  - Count clk cycles; after POR_CYCLES cycles go to WAIT_LOCK.
  - pll_lock and soft_rst_req are ignored.
- WAIT_LOCK:
  - Filter counter increments while lock_s=1 and clears to 0 when lock_s=0.
  - When the count reaches LOCK_FILTER, go to RELEASE and set released[0]=1 on the same edge.
  - soft_rst_req is ignored.
- RELEASE:
  - Gap counter counts GAP_CYCLES, then sets released[idx+1].
  - After released[N_DOM-1] has been set and a further GAP_CYCLES elapse, go to RUN.
  - N_DOM=1: RUN follows GAP_CYCLES after released[0].
- RUN: sys_ready=1; stays in RUN until a fault.
- Fault (lock_s=0 or soft_rst_req=1, while in RELEASE or RUN):
  - Next edge: state=HOLD, released mask=0, sys_ready=0.
  - If lock_s=0 (including when it coincides with soft_rst_req), lock_loss_cnt += 1, saturating at 255.
  - soft_rst_req alone does not count.
- HOLD:
  - Hold all resets for GAP_CYCLES, then go to WAIT_LOCK with the filter counter cleared.
  - Lock glitches and soft_rst_req during HOLD are ignored.
- Domain output, registered each cycle in every state: dom_rst_n[i] <= released[i] & (dom_enable[i] | force_en[i]).
  - Gating never stalls or restarts the sequence.
  - A domain disabled at its release slot comes out of reset one cycle after its enable rises.
  - Dropping an enable asserts that domain's reset one cycle later; other domains are unaffected.
- Timing, with pll_lock high from reset:
  - dom_rst_n[0] rises at edge POR_CYCLES + LOCK_FILTER + 2 after rst_n deassertion.
  - dom_rst_n[k] rises k*GAP_CYCLES edges after dom_rst_n[0].
  - sys_ready rises N_DOM*GAP_CYCLES edges after dom_rst_n[0].
- Counter widths: sized by $clog2 of the largest parameter they count to; no wrap is permitted in any state.
- rst_n asserted mid-sequence returns the block to POR immediately; lock_loss_cnt is cleared.

Test Plan:
Common parameters: POR_CYCLES=8, N_DOM=3, GAP_CYCLES=4, LOCK_FILTER=4, SYNC_STAGES=2; dom_enable=3'b111; force_en=0.
1. Clean bring-up, pll_lock=1 throughout -> dom_rst_n[0] rises at edge 14, [1] at 18, [2] at 22; sys_ready at edge 26; seq_state walks 0,1,2,3.
2. Lock low until edge 20, then high -> release starts only after 4 consecutive lock_s=1 cycles; a 1-cycle lock drop during filtering restarts the 4-cycle count.
3. In RUN, pull pll_lock low for 1 cycle -> all dom_rst_n=0 and sys_ready=0 within SYNC_STAGES+1 edges; lock_loss_cnt=1; HOLD lasts 4 cycles; full re-sequence follows; repeat 300 times -> lock_loss_cnt=255.
4. soft_rst_req pulse in RUN -> HOLD then re-sequence, lock_loss_cnt unchanged; the same pulse during POR or WAIT_LOCK has no effect.
5. dom_enable[2]=0 through the sequence, raised at edge 40 -> dom_rst_n[2] stays 0 and sys_ready still rises at edge 26; dom_rst_n[2] rises at edge 41; force_en[2]=1 alone gives the same result.
6. Assert rst_n mid-RELEASE -> all outputs 0 asynchronously; after deassertion the timing of scenario 1 repeats exactly.
